// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bundle: decoder issue fields in, stall controls out.
// master = decoder/pipeline side, slave = scoreboard. Optional HAZARD_STATS_EN adds stall_cycles_o.
interface hazard_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int LAT_W = 3
);
    localparam int RW = $clog2(NREG);

    logic [RW-1:0]    ID_RS_i;
    logic [RW-1:0]    ID_RT_i;
    logic             ID_uses_RT_i;
    logic             issue_valid_i;
    logic             issue_RegWrite_i;
    logic [RW-1:0]    issue_RD_i;
    logic [LAT_W-1:0] issue_lat_i;
    logic             flush_i;
    logic             stall_o;
    logic             PC_write_o;
    logic             IF_ID_write_o;
    logic             ID_EX_bubble_o;
    logic [NREG-1:0]  pending_o;
`ifdef HAZARD_STATS_EN
    logic [31:0]      stall_cycles_o;
`endif

    modport master (
        output ID_RS_i, ID_RT_i, ID_uses_RT_i,
        output issue_valid_i, issue_RegWrite_i,
        output issue_RD_i, issue_lat_i, flush_i,
        input  stall_o, PC_write_o,
        input  IF_ID_write_o, ID_EX_bubble_o,
`ifdef HAZARD_STATS_EN
        input  stall_cycles_o,
`endif
        input  pending_o
    );

    modport slave (
        input  ID_RS_i, ID_RT_i, ID_uses_RT_i,
        input  issue_valid_i, issue_RegWrite_i,
        input  issue_RD_i, issue_lat_i, flush_i,
        output stall_o, PC_write_o,
        output IF_ID_write_o, ID_EX_bubble_o,
`ifdef HAZARD_STATS_EN
        output stall_cycles_o,
`endif
        output pending_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Producer-side RAW hazard tracker: per-register countdown until a result is forwardable.
// Ports: clk_i, rst_n_i (async, active-low), bus (hazard_scoreboard_if.slave).
// Optional HAZARD_STATS_EN: saturating stall-cycle counter on bus.stall_cycles_o.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    hazard_scoreboard_if.slave   bus
);
    localparam int RW = $clog2(NREG);

    logic [LAT_W-1:0] r_cnt  [NREG];
    logic [LAT_W-1:0] w_next [NREG];
    logic [NREG-1:0]  w_pend;
    logic             w_rs_pend;
    logic             w_rt_pend;
    logic             w_stall;
    logic             w_accept;

    always_comb begin
        w_pend = '0;
        for (int r = 1; r < NREG; r++) begin
            w_pend[r] = (r_cnt[r] != '0);
        end
    end

    assign w_rs_pend = w_pend[bus.ID_RS_i];
    assign w_rt_pend = w_pend[bus.ID_RT_i];

    // RS == RT both pending is one hazard: the OR folds it.
    assign w_stall = bus.issue_valid_i & ~bus.flush_i &
                     (w_rs_pend | (bus.ID_uses_RT_i & w_rt_pend));

    assign w_accept = bus.issue_valid_i & ~w_stall & ~bus.flush_i &
                      bus.issue_RegWrite_i & (bus.issue_RD_i != '0);

    // Countdown saturates at 0; a new write keeps the larger of the
    // remaining and requested latency so an older, slower producer wins.
    always_comb begin
        logic [LAT_W-1:0] dec;
        for (int r = 0; r < NREG; r++) begin
            dec = (r_cnt[r] != '0) ? r_cnt[r] - LAT_W'(1) : '0;
            w_next[r] = dec;
            if (w_accept && bus.issue_RD_i == RW'(r) &&
                bus.issue_lat_i > dec) begin
                w_next[r] = bus.issue_lat_i;
            end
        end
        w_next[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= w_next[r];
            end
        end
    end

    assign bus.stall_o        = w_stall;
    assign bus.PC_write_o     = ~w_stall;
    assign bus.IF_ID_write_o  = ~w_stall;
    assign bus.ID_EX_bubble_o = w_stall;
    assign bus.pending_o      = w_pend;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cycles <= '0;
        end else if (w_stall && r_stall_cycles != '1) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles_o = r_stall_cycles;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against a ready-time reference model.
// Model: each register holds the cycle index at which its value becomes forwardable.
module tb_hazard_scoreboard;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b1;

    always #5 clk_i = ~clk_i;

    hazard_scoreboard_if #(.NREG(32), .LAT_W(3)) bus ();

    hazard_scoreboard #(.NREG(32), .LAT_W(3)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    longint ready [32];
    longint now = 0;
    longint exp_stalls = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend(int r);
        return (r != 0) && (ready[r] > now);
    endfunction

    task automatic clear_model();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        exp_stalls = 0;
    endtask

    task automatic set_in(bit v, int rs, int rt, bit u,
                          bit rw, int rd, int lat, bit fl);
        bus.issue_valid_i    = v;
        bus.ID_RS_i          = 5'(rs);
        bus.ID_RT_i          = 5'(rt);
        bus.ID_uses_RT_i     = u;
        bus.issue_RegWrite_i = rw;
        bus.issue_RD_i       = 5'(rd);
        bus.issue_lat_i      = 3'(lat);
        bus.flush_i          = fl;
    endtask

    // Check all outputs for the current cycle, then advance one edge.
    task automatic do_cycle(output bit st);
        bit          es, v, fl, rw;
        int          rd, lat;
        logic [31:0] ep;
        #1;
        v   = bus.issue_valid_i;
        fl  = bus.flush_i;
        rw  = bus.issue_RegWrite_i;
        rd  = int'(bus.issue_RD_i);
        lat = int'(bus.issue_lat_i);
        es  = rst_n_i && v && !fl &&
              (pend(int'(bus.ID_RS_i)) ||
               (bus.ID_uses_RT_i && pend(int'(bus.ID_RT_i))));
        for (int r = 0; r < 32; r++) ep[r] = rst_n_i && pend(r);
        chk("stall", bus.stall_o, es);
        chk("pc_write", bus.PC_write_o, !es);
        chk("if_id_write", bus.IF_ID_write_o, !es);
        chk("bubble", bus.ID_EX_bubble_o, es);
        chk("pending", bus.pending_o, ep);
        st = bus.stall_o;
        @(posedge clk_i);
        if (rst_n_i) begin
            if (es) exp_stalls++;
            if (v && !es && !fl && rw && rd != 0 &&
                now + lat + 1 > ready[rd])
                ready[rd] = now + lat + 1;
            now++;
        end
        #1;
    endtask

    task automatic idle(int k);
        bit st;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < k; i++) do_cycle(st);
    endtask

    task automatic issue(int rd, int lat);
        bit st;
        set_in(1, 0, 0, 0, 1, rd, lat, 0);
        do_cycle(st);
    endtask

    // Hold one reader in ID until it issues; count its stall cycles.
    task automatic run_until(string tag, int rs, int rt, bit u, int exp_n);
        bit st;
        int n = 0;
        set_in(1, rs, rt, u, 0, 0, 0, 0);
        do_cycle(st);
        while (st && n < 16) begin
            n++;
            do_cycle(st);
        end
        chk(tag, n, exp_n);
    endtask

    task automatic rand_in();
        int rs, rt, rd;
        rs = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31)
                                          : $urandom_range(0, 7);
        rt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31)
                                          : $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        set_in($urandom_range(0, 4) != 0, rs, rt,
               1'($urandom_range(0, 1)),
               $urandom_range(0, 9) < 7, rd,
               $urandom_range(0, 7),
               $urandom_range(0, 9) == 0);
    endtask

    initial begin
        bit st;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held with random inputs.
        rst_n_i = 1'b0;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            rand_in();
            do_cycle(st);
        end
        rst_n_i = 1'b1;
        idle(1);

        // Load-use: one bubble.
        issue(8, 1);
        run_until("load_use", 8, 0, 0, 1);

        // RT only hazards when the instruction reads RT.
        issue(5, 3);
        run_until("rt_unused", 0, 5, 0, 0);
        idle(4);
        issue(5, 3);
        run_until("rt_used", 0, 5, 1, 3);

        // RD = 0 is never recorded.
        issue(0, 3);
        chk("rd0_pending", bus.pending_o, 32'd0);
        run_until("rd0_stall", 0, 0, 0, 0);

        // WAW keeps the longer outstanding latency.
        issue(9, 3);
        issue(9, 1);
        run_until("waw", 9, 0, 0, 2);

        // RS == RT pending: still one stall per cycle.
        issue(6, 2);
        run_until("rs_eq_rt", 6, 6, 1, 2);

        // Flushed instruction records nothing.
        set_in(1, 0, 0, 0, 1, 4, 2, 1);
        do_cycle(st);
        chk("flush_pend4", bus.pending_o[4], 1'b0);
        run_until("flush_stall", 4, 0, 0, 0);

`ifdef HAZARD_STATS_EN
        chk("stats_directed", bus.stall_cycles_o, 32'(exp_stalls));
`endif

        // Asynchronous reset mid-countdown.
        issue(7, 2);
        set_in(1, 7, 0, 0, 0, 0, 0, 0);
        #2;
        chk("pre_rst_p7", bus.pending_o[7], 1'b1);
        rst_n_i = 1'b0;
        #1;
        chk("rst_pending", bus.pending_o, 32'd0);
        chk("rst_stall", bus.stall_o, 1'b0);
        clear_model();
`ifdef HAZARD_STATS_EN
        chk("rst_stats", bus.stall_cycles_o, 32'd0);
`endif
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            do_cycle(st);
        end

`ifdef HAZARD_STATS_EN
        chk("stats_random", bus.stall_cycles_o, 32'(exp_stalls));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
